// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants used by the fetch unit and the control FSM.
//   pc_op_t          : PC operation codes driven by the control FSM
//   CPU_RESET_VECTOR : PC value loaded on reset and on PC_RESET
//   fetch_state_t    : fetch FSM states
//   fetch_tgt_t      : destination register of an outstanding read
package fetch_unit_pkg;

  localparam logic [15:0] CPU_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    PC_NOP   = 2'd0,
    PC_INC   = 2'd1,
    PC_SET   = 2'd2,
    PC_RESET = 2'd3
  } pc_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } fetch_state_t;

  typedef enum logic {
    TGT_INSTR = 1'b0,
    TGT_IMM   = 1'b1
  } fetch_tgt_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register and its update logic.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update enable; with en=0 the PC holds
//   pc_op      : NOP holds, INC adds 2 (wraps), SET loads pc_in halfword-aligned,
//                RESET loads RESET_VECTOR
//   pc_in      : branch target
//   pc         : current PC
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = CPU_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  pc_op_t      pc_op,
  input  logic [15:0] pc_in,
  output logic [15:0] pc
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (en) begin
      case (pc_op)
        PC_INC:   pc <= pc + 16'd2;          // 0xFFFE wraps to 0x0000
        PC_SET:   pc <= pc_in & 16'hFFFE;    // instructions are halfword aligned
        PC_RESET: pc <= RESET_VECTOR;
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction / immediate fetch unit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : gates PC updates and request acceptance
//   pc_op, pc_in        : PC operation and branch target
//   fetch_req, imm_req  : fetch instruction / immediate word (fetch wins if both)
//   mem_ack, mem_rdata  : memory read completion and data
//   mem_req, mem_addr   : registered read request and address
//   pc_o                : current PC
//   instr_o, imm_o      : last fetched instruction / immediate word
//   busy                : high while a read is outstanding (pipeline stall)
//   bus_err             : sticky error (collision, request while busy, timeout)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = CPU_RESET_VECTOR,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pc_op,
  input  logic [15:0] pc_in,
  input  logic        fetch_req,
  input  logic        imm_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] pc_o,
  output logic [15:0] instr_o,
  output logic [15:0] imm_o,
  output logic        busy,
  output logic        bus_err
);

  fetch_state_t state, state_next;
  fetch_tgt_t   tgt;
  logic [7:0]   wait_cnt;
  logic         any_req;
  logic         accept;
  logic         timeout_hit;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .pc_op (pc_op_t'(pc_op)),
    .pc_in (pc_in),
    .pc    (pc_o)
  );

  assign any_req = fetch_req | imm_req;
  assign accept  = (state == ST_IDLE) && en && any_req;
  // Fires on the TIMEOUT-th consecutive BUS cycle without an ack.
  assign timeout_hit = (state == ST_BUS) && !mem_ack && (wait_cnt == TIMEOUT - 8'd1);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)                 state_next = ST_BUS;
      ST_BUS:  if (mem_ack || timeout_hit) state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= 16'h0000;
      tgt      <= TGT_INSTR;
      wait_cnt <= 8'd0;
      instr_o  <= 16'h0000;
      imm_o    <= 16'h0000;
      bus_err  <= 1'b0;
    end else begin
      if (accept) begin
        // Address is the PC before any pc_op applied on this same edge.
        mem_req  <= 1'b1;
        mem_addr <= pc_o;
        tgt      <= fetch_req ? TGT_INSTR : TGT_IMM;
        wait_cnt <= 8'd0;
        if (fetch_req && imm_req) bus_err <= 1'b1;
      end

      if (state == ST_BUS) begin
        // Requests while busy are dropped but flagged; en does not stall BUS.
        if (any_req) bus_err <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (tgt == TGT_INSTR) instr_o <= mem_rdata;
          else                  imm_o   <= mem_rdata;
        end else if (timeout_hit) begin
          mem_req <= 1'b0;
          bus_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000, meaning the PC value loaded on reset and on PC_RESET.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, meaning the maximum number of wait cycles before a bus error.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, global advance enable; gates PC updates and request acceptance.
REQ-006 SHALL have port pc_op, input, 2, PC operation code from the control FSM: PC_NOP, PC_INC, PC_SET or PC_RESET.
REQ-007 SHALL have port pc_in, input, 16, branch target used by PC_SET.
REQ-008 SHALL have port fetch_req, input, 1, fetch-instruction request, driven from the control fetch bit.
REQ-009 SHALL have port imm_req, input, 1, fetch-immediate-word request.
REQ-010 SHALL have port mem_ack, input, 1, memory read completion.
REQ-011 SHALL have port mem_rdata, input, 16, memory read data, valid when mem_ack is high.
REQ-012 SHALL have port mem_req, output, 1, read request; registered.
REQ-013 SHALL have port mem_addr, output, 16, read address; registered.
REQ-014 SHALL have port pc_o, output, 16, current PC.
REQ-015 SHALL have port instr_o, output, 16, last fetched instruction word.
REQ-016 SHALL have port imm_o, output, 16, last fetched immediate word.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE; used as the pipeline stall (mem_wait) source.
REQ-018 SHALL have port bus_err, output, 1, sticky error flag.

Function
REQ-019 PC update SHALL occur only when en=1: PC_NOP holds; PC_INC sets pc+2 modulo 2^16 (0xFFFE wraps to 0x0000); PC_SET loads {pc_in[15:1],1'b0}; PC_RESET loads RESET_VECTOR.
REQ-020 A request accepted in the same cycle as a pc_op update SHALL use the pre-update PC as its address.
REQ-021 The FSM SHALL have two states, IDLE and BUS.
REQ-022 In IDLE with en=1 and fetch_req or imm_req high, the FSM SHALL latch mem_addr=pc, record the target (instr or imm), assert mem_req and move to BUS on the next edge.
REQ-023 If fetch_req and imm_req are high together, fetch_req SHALL win; imm_req is dropped and bus_err is set.
REQ-024 In BUS, mem_req and mem_addr SHALL stay constant; on a cycle with mem_ack=1, mem_rdata SHALL be captured into the target register, mem_req SHALL deassert and the FSM SHALL return to IDLE.
REQ-025 Latency: with memory acknowledging in the first BUS cycle, instr_o/imm_o SHALL update 2 edges after acceptance and busy SHALL be high for exactly 1 cycle.
REQ-026 A wait counter SHALL clear on entry to BUS and increment on each BUS cycle with mem_ack=0; on reaching TIMEOUT, the FSM SHALL deassert mem_req, return to IDLE, set bus_err and leave the target register unchanged.
REQ-027 A request arriving while busy=1 SHALL be ignored and SHALL set bus_err.
REQ-028 mem_ack while in IDLE SHALL be ignored.
REQ-029 en=0 SHALL NOT stall an in-flight BUS transaction.
REQ-030 bus_err SHALL clear only on reset.

Reset
REQ-031 rst_n low SHALL immediately set pc_o=RESET_VECTOR, state=IDLE, mem_req=0, mem_addr=0, instr_o=0, imm_o=0, wait counter=0 and bus_err=0.
REQ-032 Reset during BUS SHALL abort the transaction; an ack after reset release SHALL be ignored per REQ-028.

Structure
REQ-033 The pc_op codes (PC_NOP, PC_INC, PC_SET, PC_RESET) and RESET_VECTOR SHALL come from the shared cpu_constants header, unchanged from the control FSM's usage.
REQ-034 PC register and update logic SHALL be one sub-module, pc_reg; the FSM, counter and data registers SHALL stay in fetch_unit.

Verification
REQ-035 Reset, then en=1, fetch_req=1 and pc_op=PC_INC for 1 cycle, mem_ack=1 with rdata=0x1234 in the first BUS cycle -> mem_addr=0x0000, pc_o=0x0002, instr_o=0x1234 after 2 edges.
REQ-036 pc_op=PC_SET with pc_in=0x4567 -> pc_o=0x4566; then PC_INC from 0xFFFE -> pc_o=0x0000.
REQ-037 imm_req with mem_ack delayed 5 cycles and rdata=0xBEEF -> mem_req high for 6 cycles with constant address, imm_o=0xBEEF, instr_o unchanged.
REQ-038 fetch_req with mem_ack never asserted -> mem_req drops after 255 wait cycles, bus_err=1, busy=0.
REQ-039 fetch_req asserted during BUS, and fetch_req and imm_req asserted together -> bus_err=1, only one transaction issued.
REQ-040 rst_n low mid-BUS, then mem_ack pulsed after release -> mem_req=0 immediately, instr_o stays 0.
